// File: rtl/axi_mm_traffic_master.sv
// AXI4 memory-mapped traffic initiator for unit simulation.
// Writes num_bursts bursts of a deterministic pattern, then reads the same
// addresses back. It can optionally compare the read data and counts
// protocol and data errors. Only one transaction is outstanding at a time.
module axi_mm_traffic_master #(
  parameter int AXI_ID_WIDTH     = 5,
  parameter int AXI_ADDR_WIDTH   = 64,
  parameter int AXI_DATA_WIDTH   = 1024,
  parameter int AXI_AWUSER_WIDTH = 9,
  parameter int AXI_ARUSER_WIDTH = 9
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [AXI_ADDR_WIDTH-1:0]     base_addr,
  input  logic [7:0]                    burst_len,
  input  logic [15:0]                   num_bursts,
  input  logic                          check_en,
  output logic                          busy,
  output logic                          done,
  output logic [15:0]                   err_cnt,
  output logic                          m_axi_awvalid,
  output logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [AXI_ID_WIDTH-1:0]       m_axi_awid,
  output logic [7:0]                    m_axi_awlen,
  output logic [2:0]                    m_axi_awsize,
  output logic [1:0]                    m_axi_awburst,
  output logic [AXI_AWUSER_WIDTH-1:0]   m_axi_awuser,
  input  logic                          m_axi_awready,
  output logic                          m_axi_wvalid,
  output logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                          m_axi_wlast,
  input  logic                          m_axi_wready,
  input  logic                          m_axi_bvalid,
  input  logic [AXI_ID_WIDTH-1:0]       m_axi_bid,
  input  logic [1:0]                    m_axi_bresp,
  output logic                          m_axi_bready,
  output logic                          m_axi_arvalid,
  output logic [AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [AXI_ID_WIDTH-1:0]       m_axi_arid,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  output logic [AXI_ARUSER_WIDTH-1:0]   m_axi_aruser,
  input  logic                          m_axi_arready,
  input  logic                          m_axi_rvalid,
  input  logic [AXI_DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [AXI_ID_WIDTH-1:0]       m_axi_rid,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rlast,
  output logic                          m_axi_rready
);

  localparam int BYTES     = AXI_DATA_WIDTH / 8;
  localparam int SIZE_LOG2 = $clog2(BYTES);
  localparam int LANES     = AXI_DATA_WIDTH / 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AW,
    S_W,
    S_B,
    S_AR,
    S_R,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [AXI_ADDR_WIDTH-1:0] base_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [AXI_ADDR_WIDTH-1:0] stride;
  logic [7:0]                len_q;
  logic [15:0]               nb_q;
  logic                      chk_q;
  logic [15:0]               k_q;
  logic [7:0]                b_q;
  logic [AXI_ID_WIDTH-1:0]   cur_id;
  logic [31:0]               lane_pat;
  logic [AXI_DATA_WIDTH-1:0] pattern;

  logic start_acc;
  logic last_burst;
  logic last_beat;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic b_err, r_err;

  assign start_acc  = start && ((state == S_IDLE) || (state == S_DONE));
  assign last_burst = (k_q == (nb_q - 16'd1));
  assign last_beat  = (b_q == len_q);

  // Address step between bursts is one full burst worth of bytes.
  assign stride = (AXI_ADDR_WIDTH'(len_q) + AXI_ADDR_WIDTH'(1)) << SIZE_LOG2;

  assign cur_id   = AXI_ID_WIDTH'(k_q);
  assign lane_pat = {k_q, b_q, 8'h5A};
  assign pattern  = {LANES{lane_pat}};

  assign aw_hs = m_axi_awvalid && m_axi_awready;
  assign w_hs  = m_axi_wvalid && m_axi_wready;
  assign b_hs  = m_axi_bvalid && m_axi_bready;
  assign ar_hs = m_axi_arvalid && m_axi_arready;
  assign r_hs  = m_axi_rvalid && m_axi_rready;

  assign b_err = (m_axi_bresp != 2'b00) || (m_axi_bid != cur_id);
  assign r_err = (m_axi_rresp != 2'b00) || (m_axi_rid != cur_id) ||
                 (m_axi_rlast != last_beat) ||
                 (chk_q && (m_axi_rdata != pattern));

  // Address and fixed channel fields come straight from the burst registers.
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awid    = cur_id;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = 3'(SIZE_LOG2);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awuser  = '0;
  assign m_axi_wdata   = pattern;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = last_beat;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arid    = cur_id;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = 3'(SIZE_LOG2);
  assign m_axi_arburst = 2'b01;
  assign m_axi_aruser  = '0;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and state-decoded channel controls.
  always_comb begin
    state_nxt     = state;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        busy = 1'b0;
        done = (state == S_DONE);
        if (start) state_nxt = (num_bursts == 16'd0) ? S_DONE : S_AW;
      end
      S_AW: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_nxt = S_W;
      end
      S_W: begin
        m_axi_wvalid = 1'b1;
        if (m_axi_wready && last_beat) state_nxt = S_B;
      end
      S_B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_nxt = last_burst ? S_AR : S_AW;
      end
      S_AR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_nxt = S_R;
      end
      S_R: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid && last_beat) state_nxt = last_burst ? S_DONE : S_AR;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Burst bookkeeping: parameter capture, burst index, beat index, address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      addr_q <= '0;
      len_q  <= '0;
      nb_q   <= '0;
      chk_q  <= 1'b0;
      k_q    <= '0;
      b_q    <= '0;
    end else if (start_acc) begin
      base_q <= base_addr;
      addr_q <= base_addr;
      len_q  <= burst_len;
      nb_q   <= num_bursts;
      chk_q  <= check_en;
      k_q    <= '0;
      b_q    <= '0;
    end else begin
      case (state)
        S_AW: if (aw_hs) b_q <= '0;
        S_AR: if (ar_hs) b_q <= '0;
        S_W:  if (w_hs) b_q <= b_q + 8'd1;
        S_B: begin
          if (b_hs) begin
            if (last_burst) begin
              k_q    <= '0;
              addr_q <= base_q;
            end else begin
              k_q    <= k_q + 16'd1;
              addr_q <= addr_q + stride;
            end
          end
        end
        S_R: begin
          if (r_hs) begin
            b_q <= b_q + 8'd1;
            if (last_beat) begin
              k_q    <= k_q + 16'd1;
              addr_q <= addr_q + stride;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Saturating error counter, cleared whenever a new run is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (start_acc) begin
      err_cnt <= '0;
    end else if (((b_hs && b_err) || (r_hs && r_err)) && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_axi_mm_traffic_master.sv
// Self-checking bench for axi_mm_traffic_master: an AXI responder with an
// optional memory model and random backpressure, plus a reference model
// that predicts addresses, ids, write beats and error counts per run.
module tb_axi_mm_traffic_master;

  localparam int IDW = 5;
  localparam int AW  = 64;
  localparam int DW  = 1024;
  localparam int UW  = 9;
  localparam logic [63:0] BYTES = 64'(DW / 8);

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [AW-1:0]   base_addr;
  logic [7:0]      burst_len;
  logic [15:0]     num_bursts;
  logic            check_en;
  logic            busy, done;
  logic [15:0]     err_cnt;
  logic            m_axi_awvalid, m_axi_awready;
  logic [AW-1:0]   m_axi_awaddr;
  logic [IDW-1:0]  m_axi_awid;
  logic [7:0]      m_axi_awlen;
  logic [2:0]      m_axi_awsize;
  logic [1:0]      m_axi_awburst;
  logic [UW-1:0]   m_axi_awuser;
  logic            m_axi_wvalid, m_axi_wready, m_axi_wlast;
  logic [DW-1:0]   m_axi_wdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic            m_axi_bvalid, m_axi_bready;
  logic [IDW-1:0]  m_axi_bid;
  logic [1:0]      m_axi_bresp;
  logic            m_axi_arvalid, m_axi_arready;
  logic [AW-1:0]   m_axi_araddr;
  logic [IDW-1:0]  m_axi_arid;
  logic [7:0]      m_axi_arlen;
  logic [2:0]      m_axi_arsize;
  logic [1:0]      m_axi_arburst;
  logic [UW-1:0]   m_axi_aruser;
  logic            m_axi_rvalid, m_axi_rready, m_axi_rlast;
  logic [DW-1:0]   m_axi_rdata;
  logic [IDW-1:0]  m_axi_rid;
  logic [1:0]      m_axi_rresp;

  int checks = 0;
  int errors = 0;

  // Responder configuration and observation log.
  bit zero_data = 1'b1;
  bit bp        = 1'b0;
  int bresp_err_burst = -1;
  bit any_valid = 1'b0;
  logic [63:0]   aw_addr_q[$];
  logic [IDW-1:0] aw_id_q[$];
  logic [DW-1:0] w_data_q[$];
  logic          w_last_q[$];
  logic [63:0]   ar_addr_q[$];
  logic [IDW-1:0] ar_id_q[$];
  logic [DW-1:0] mem [logic [63:0]];

  always #5 clk = ~clk;

  axi_mm_traffic_master #(
    .AXI_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW),
    .AXI_AWUSER_WIDTH(UW), .AXI_ARUSER_WIDTH(UW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .burst_len(burst_len), .num_bursts(num_bursts), .check_en(check_en),
    .busy(busy), .done(done), .err_cnt(err_cnt),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awid(m_axi_awid),
    .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awuser(m_axi_awuser), .m_axi_awready(m_axi_awready),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wready(m_axi_wready),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
    .m_axi_bready(m_axi_bready),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_araddr(m_axi_araddr), .m_axi_arid(m_axi_arid),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_aruser(m_axi_aruser), .m_axi_arready(m_axi_arready),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rdata(m_axi_rdata), .m_axi_rid(m_axi_rid),
    .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast), .m_axi_rready(m_axi_rready)
  );

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_data(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed(lo64) %0h expected(lo64) %0h", tag, obs[63:0], exp[63:0]);
    end
  endtask

  // Write pattern: every 32-bit lane carries {burst[15:0], beat[7:0], 8'h5A}.
  function automatic logic [DW-1:0] pat(input int k, input int b);
    logic [31:0] lane;
    logic [DW-1:0] p;
    lane = {k[15:0], b[7:0], 8'h5A};
    for (int i = 0; i < DW / 32; i++) p[i*32 +: 32] = lane;
    return p;
  endfunction

  function automatic logic go();
    return !bp || ($urandom_range(0, 2) != 0);
  endfunction

  // AXI responder: drives on the falling edge, predicting the handshakes of
  // the following rising edge from the now-stable DUT outputs.
  initial begin : responder
    logic aw_wait, w_wait, ar_wait, b_fire, b_pending, r_fire, r_active;
    logic [63:0] aw_hold, ar_hold, w_base, r_base, a;
    logic [DW-1:0] w_hold;
    logic [IDW-1:0] w_id, r_id;
    logic [7:0] r_len;
    int w_beat, r_beat;
    {m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_arready, m_axi_rvalid, m_axi_rlast} = '0;
    m_axi_bid = '0; m_axi_bresp = '0; m_axi_rid = '0; m_axi_rresp = '0; m_axi_rdata = '0;
    {aw_wait, w_wait, ar_wait, b_fire, b_pending, r_fire, r_active} = '0;
    aw_hold = '0; ar_hold = '0; w_base = '0; r_base = '0; w_hold = '0;
    w_id = '0; r_id = '0; r_len = '0; w_beat = 0; r_beat = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        {m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_arready, m_axi_rvalid, m_axi_rlast} = '0;
        {aw_wait, w_wait, ar_wait, b_fire, b_pending, r_fire, r_active} = '0;
        continue;
      end
      if (m_axi_awvalid || m_axi_wvalid || m_axi_arvalid) any_valid = 1'b1;
      // B channel
      if (b_fire) begin m_axi_bvalid = 1'b0; b_fire = 1'b0; end
      if (b_pending && !m_axi_bvalid && go()) begin
        m_axi_bvalid = 1'b1;
        m_axi_bid    = w_id;
        m_axi_bresp  = (int'(w_id) == bresp_err_burst) ? 2'b10 : 2'b00;
        b_pending    = 1'b0;
      end
      if (m_axi_bvalid && m_axi_bready) b_fire = 1'b1;
      // W channel
      m_axi_wready = go();
      if (m_axi_wvalid) begin
        if (w_wait) check_data("wdata_stable", m_axi_wdata, w_hold);
        if (m_axi_wready) begin
          w_data_q.push_back(m_axi_wdata);
          w_last_q.push_back(m_axi_wlast);
          mem[w_base + 64'(w_beat) * BYTES] = m_axi_wdata;
          w_beat++;
          w_wait = 1'b0;
          if (m_axi_wlast) b_pending = 1'b1;
        end else begin
          w_wait = 1'b1;
          w_hold = m_axi_wdata;
        end
      end
      // AW channel
      m_axi_awready = go();
      if (m_axi_awvalid) begin
        if (aw_wait) check_output("awaddr_stable", m_axi_awaddr, aw_hold);
        if (m_axi_awready) begin
          aw_addr_q.push_back(m_axi_awaddr);
          aw_id_q.push_back(m_axi_awid);
          w_base = m_axi_awaddr; w_id = m_axi_awid; w_beat = 0; aw_wait = 1'b0;
        end else begin
          aw_wait = 1'b1; aw_hold = m_axi_awaddr;
        end
      end
      // R channel
      if (r_fire) begin
        m_axi_rvalid = 1'b0; r_fire = 1'b0; r_beat++;
        if (r_beat > int'(r_len)) r_active = 1'b0;
      end
      if (r_active && !m_axi_rvalid && go()) begin
        a = r_base + 64'(r_beat) * BYTES;
        m_axi_rvalid = 1'b1;
        m_axi_rid    = r_id;
        m_axi_rresp  = 2'b00;
        m_axi_rlast  = (r_beat == int'(r_len));
        m_axi_rdata  = (zero_data || !mem.exists(a)) ? '0 : mem[a];
      end
      if (m_axi_rvalid && m_axi_rready) r_fire = 1'b1;
      // AR channel
      m_axi_arready = go();
      if (m_axi_arvalid) begin
        if (ar_wait) check_output("araddr_stable", m_axi_araddr, ar_hold);
        if (m_axi_arready) begin
          ar_addr_q.push_back(m_axi_araddr);
          ar_id_q.push_back(m_axi_arid);
          r_base = m_axi_araddr; r_id = m_axi_arid; r_len = m_axi_arlen;
          r_beat = 0; r_active = 1'b1; ar_wait = 1'b0;
        end else begin
          ar_wait = 1'b1; ar_hold = m_axi_araddr;
        end
      end
    end
  end

  // Pulse start with a parameter set and clear the observation log.
  task automatic apply_stimulus(input logic [63:0] base, input int len, input int nb, input bit chk);
    aw_addr_q.delete(); aw_id_q.delete(); w_data_q.delete(); w_last_q.delete();
    ar_addr_q.delete(); ar_id_q.delete();
    any_valid = 1'b0;
    @(negedge clk);
    base_addr = base; burst_len = 8'(len); num_bursts = 16'(nb); check_en = chk;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 5000; i++) begin
      if (done) break;
      @(negedge clk);
    end
    check_output({tag, "_done"}, 64'(done), 64'd1);
  endtask

  // Compare one finished run against the model built from the run parameters.
  task automatic check_run(input string tag, input logic [63:0] base, input int len,
                           input int nb, input int exp_err);
    int nbeats;
    logic [63:0] ea;
    nbeats = nb * (len + 1);
    check_output({tag, "_aw_count"}, 64'(aw_addr_q.size()), 64'(nb));
    check_output({tag, "_ar_count"}, 64'(ar_addr_q.size()), 64'(nb));
    check_output({tag, "_w_count"}, 64'(w_data_q.size()), 64'(nbeats));
    for (int k = 0; k < nb; k++) begin
      ea = base + 64'(k) * (64'(len) + 64'd1) * BYTES;
      if (k < aw_addr_q.size()) begin
        check_output({tag, "_awaddr"}, aw_addr_q[k], ea);
        check_output({tag, "_awid"}, 64'(aw_id_q[k]), 64'(k % 32));
      end
      if (k < ar_addr_q.size()) begin
        check_output({tag, "_araddr"}, ar_addr_q[k], ea);
        check_output({tag, "_arid"}, 64'(ar_id_q[k]), 64'(k % 32));
      end
    end
    for (int i = 0; i < nbeats && i < w_data_q.size(); i++) begin
      check_data({tag, "_wdata"}, w_data_q[i], pat(i / (len + 1), i % (len + 1)));
      check_output({tag, "_wlast"}, 64'(w_last_q[i]), 64'((i % (len + 1)) == len));
    end
    check_output({tag, "_busy"}, 64'(busy), 64'd0);
    check_output({tag, "_err_cnt"}, 64'(err_cnt), 64'(exp_err));
  endtask

  initial begin : main
    logic [63:0] rb;
    int rl, rn;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; burst_len = '0; num_bursts = '0; check_en = 1'b0;
    repeat (3) @(negedge clk);
    $display("[TB] reset state");
    check_output("rst_valids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}), 64'd0);
    check_output("rst_busy", 64'(busy), 64'd0);
    check_output("rst_done", 64'(done), 64'd0);
    check_output("rst_err", 64'(err_cnt), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] zero bursts");
    apply_stimulus(64'h1000, 3, 0, 1'b0);
    check_output("nb0_done", 64'(done), 64'd1);
    check_output("nb0_busy", 64'(busy), 64'd0);
    repeat (5) @(negedge clk);
    check_output("nb0_no_valid", 64'(any_valid), 64'd0);

    $display("[TB] zero-data responder, no compare, start while busy");
    zero_data = 1'b1; bp = 1'b0; bresp_err_burst = -1;
    apply_stimulus(64'h1000, 3, 2, 1'b0);
    check_output("run1_busy", 64'(busy), 64'd1);
    check_output("run1_done_clr", 64'(done), 64'd0);
    repeat (2) @(negedge clk);
    base_addr = 64'h8000; burst_len = 8'd0; num_bursts = 16'd5; check_en = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("run1");
    check_run("run1", 64'h1000, 3, 2, 0);

    $display("[TB] zero-data responder with compare");
    apply_stimulus(64'h1000, 3, 2, 1'b1);
    wait_done("run2");
    check_run("run2", 64'h1000, 3, 2, 8);
    repeat (3) @(negedge clk);
    check_output("run2_done_held", 64'(done), 64'd1);

    $display("[TB] memory responder with backpressure, single beats");
    zero_data = 1'b0; bp = 1'b1;
    apply_stimulus(64'h2_0000, 0, 16, 1'b1);
    wait_done("run3");
    check_run("run3", 64'h2_0000, 0, 16, 0);

    $display("[TB] bresp error on burst 1");
    bp = 1'b0; bresp_err_burst = 1;
    apply_stimulus(64'h4_0000, 1, 3, 1'b1);
    wait_done("run4");
    check_run("run4", 64'h4_0000, 1, 3, 1);
    bresp_err_burst = -1;

    $display("[TB] address wrap");
    bp = 1'b1;
    apply_stimulus(64'hFFFF_FFFF_FFFF_FF00, 1, 3, 1'b1);
    wait_done("run5");
    check_run("run5", 64'hFFFF_FFFF_FFFF_FF00, 1, 3, 0);

    $display("[TB] random runs");
    for (int r = 0; r < 3; r++) begin
      rb = {$urandom, $urandom};
      rl = $urandom_range(0, 7);
      rn = $urandom_range(1, 6);
      apply_stimulus(rb, rl, rn, 1'b1);
      wait_done("rand");
      check_run("rand", rb, rl, rn, 0);
    end

    $display("[TB] reset in the middle of the write phase");
    bp = 1'b0;
    apply_stimulus(64'h9000, 7, 4, 1'b1);
    for (int i = 0; i < 200; i++) begin
      if (m_axi_wvalid) break;
      @(negedge clk);
    end
    check_output("mid_w_seen", 64'(m_axi_wvalid), 64'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("abort_valids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}), 64'd0);
    check_output("abort_busy", 64'(busy), 64'd0);
    check_output("abort_done", 64'(done), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bp = 1'b1;
    apply_stimulus(64'h9000, 2, 3, 1'b1);
    wait_done("after_rst");
    check_run("after_rst", 64'h9000, 2, 3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
